// File: rtl/crem_pkg.sv
// Shared constants for the command receiver: opcodes, FSM state encoding and
// the fixed register-file addresses used by the two-operand ALU command.
package crem_pkg;

    localparam logic [7:0] OPC_WRITE = 8'hAA;
    localparam logic [7:0] OPC_READ  = 8'hBB;
    localparam logic [7:0] OPC_OPER  = 8'hCC;
    localparam logic [7:0] OPC_ALU   = 8'hDD;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_ADDR = 3'd1;
    localparam logic [2:0] ST_WR_DATA = 3'd2;
    localparam logic [2:0] ST_RD_ADDR = 3'd3;
    localparam logic [2:0] ST_OP_A    = 3'd4;
    localparam logic [2:0] ST_OP_B    = 3'd5;
    localparam logic [2:0] ST_ALU_FUN = 3'd6;
    localparam logic [2:0] ST_ISSUE   = 3'd7;

    localparam int ADDR_OP_A = 0;
    localparam int ADDR_OP_B = 1;

    // Unknown opcodes map to ST_IDLE, which the FSM treats as a decode error.
    function automatic logic [2:0] opcode_next(input logic [7:0] opc);
        case (opc)
            OPC_WRITE: return ST_WR_ADDR;
            OPC_READ:  return ST_RD_ADDR;
            OPC_OPER:  return ST_OP_A;
            OPC_ALU:   return ST_ALU_FUN;
            default:   return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Inter-byte idle counter: clears on request, saturates at TIMEOUT_CYC-1 and
// flags done while saturated.
module frame_timer #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic done
);

    localparam int               CNT_W   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: flops update with non-blocking assignments only; reset is asynchronous, active low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == CNT_MAX);

endmodule

// File: rtl/rx_cmd_ctrl.sv
// Byte-stream command decoder: turns UART bytes into register-file writes and
// reads and ALU execute strobes, with an inter-byte timeout.
module rx_cmd_ctrl
    import crem_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              tx_busy,
    output logic              rf_wr_en,
    output logic              rf_rd_en,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [7:0]        rf_wr_data,
    output logic              alu_en,
    output logic [3:0]        alu_fun,
    output logic              clk_gate_en,
    output logic              cmd_err
);

    logic [2:0]        state_q, state_d;
    logic              issue_alu_q, issue_alu_d;
    logic              rf_wr_en_q, rf_wr_en_d;
    logic              rf_rd_en_q, rf_rd_en_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [7:0]        rf_wr_data_q, rf_wr_data_d;
    logic              alu_en_q, alu_en_d;
    logic [3:0]        alu_fun_q, alu_fun_d;
    logic              clk_gate_en_q, clk_gate_en_d;
    logic              cmd_err_q, cmd_err_d;

    logic timer_clr, timer_done, timeout;

    assign timer_clr = rx_valid || (state_q == ST_IDLE);

    frame_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_frame_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (timer_clr),
        .done (timer_done)
    );

    // A byte arriving on the timeout cycle wins; ISSUE waits on tx_busy indefinitely.
    assign timeout = timer_done && !rx_valid && (state_q != ST_IDLE) && (state_q != ST_ISSUE);

    always_comb begin
        state_d      = state_q;
        issue_alu_d  = issue_alu_q;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        alu_en_d     = 1'b0;
        cmd_err_d    = 1'b0;
        rf_addr_d    = rf_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        alu_fun_d    = alu_fun_q;

        case (state_q)
            ST_IDLE: if (rx_valid) begin
                state_d   = opcode_next(rx_data);
                cmd_err_d = (state_d == ST_IDLE);
            end
            ST_WR_ADDR: if (rx_valid) begin
                rf_addr_d = rx_data[ADDR_W-1:0];
                state_d   = ST_WR_DATA;
            end
            ST_WR_DATA: if (rx_valid) begin
                rf_wr_data_d = rx_data;
                rf_wr_en_d   = 1'b1;
                state_d      = ST_IDLE;
            end
            ST_RD_ADDR: if (rx_valid) begin
                rf_addr_d   = rx_data[ADDR_W-1:0];
                issue_alu_d = 1'b0;
                state_d     = ST_ISSUE;
            end
            ST_OP_A: if (rx_valid) begin
                rf_addr_d    = ADDR_W'(ADDR_OP_A);
                rf_wr_data_d = rx_data;
                rf_wr_en_d   = 1'b1;
                state_d      = ST_OP_B;
            end
            ST_OP_B: if (rx_valid) begin
                rf_addr_d    = ADDR_W'(ADDR_OP_B);
                rf_wr_data_d = rx_data;
                rf_wr_en_d   = 1'b1;
                state_d      = ST_ALU_FUN;
            end
            ST_ALU_FUN: if (rx_valid) begin
                alu_fun_d   = rx_data[3:0];
                issue_alu_d = 1'b1;
                state_d     = ST_ISSUE;
            end
            ST_ISSUE: begin
                cmd_err_d = rx_valid;
                if (!tx_busy) begin
                    alu_en_d   = issue_alu_q;
                    rf_rd_en_d = !issue_alu_q;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (timeout) begin
            state_d   = ST_IDLE;
            cmd_err_d = 1'b1;
        end

        // The gate covers the whole ALU frame, the alu_en cycle and the one after it.
        clk_gate_en_d = (state_d == ST_OP_A) || (state_d == ST_OP_B) || (state_d == ST_ALU_FUN)
                     || ((state_d == ST_ISSUE) && issue_alu_d) || alu_en_d || alu_en_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            issue_alu_q   <= 1'b0;
            rf_wr_en_q    <= 1'b0;
            rf_rd_en_q    <= 1'b0;
            rf_addr_q     <= '0;
            rf_wr_data_q  <= '0;
            alu_en_q      <= 1'b0;
            alu_fun_q     <= '0;
            clk_gate_en_q <= 1'b0;
            cmd_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            issue_alu_q   <= issue_alu_d;
            rf_wr_en_q    <= rf_wr_en_d;
            rf_rd_en_q    <= rf_rd_en_d;
            rf_addr_q     <= rf_addr_d;
            rf_wr_data_q  <= rf_wr_data_d;
            alu_en_q      <= alu_en_d;
            alu_fun_q     <= alu_fun_d;
            clk_gate_en_q <= clk_gate_en_d;
            cmd_err_q     <= cmd_err_d;
        end
    end

    assign rf_wr_en    = rf_wr_en_q;
    assign rf_rd_en    = rf_rd_en_q;
    assign rf_addr     = rf_addr_q;
    assign rf_wr_data  = rf_wr_data_q;
    assign alu_en      = alu_en_q;
    assign alu_fun     = alu_fun_q;
    assign clk_gate_en = clk_gate_en_q;
    assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// Self-checking bench for rx_cmd_ctrl: a frame-level queue model checked every
// cycle, plus directed literal expectations at the interesting points.
module tb_rx_cmd_ctrl;

    localparam int ADDR_W      = 4;
    localparam int TIMEOUT_CYC = 16;

    logic              clk      = 1'b0;
    logic              rst      = 1'b0;
    logic [7:0]        rx_data  = 8'h00;
    logic              rx_valid = 1'b0;
    logic              tx_busy  = 1'b0;
    logic              rf_wr_en, rf_rd_en, alu_en, clk_gate_en, cmd_err;
    logic [ADDR_W-1:0] rf_addr;
    logic [7:0]        rf_wr_data;
    logic [3:0]        alu_fun;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_on   = 1'b0;

    rx_cmd_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_busy     (tx_busy),
        .rf_wr_en    (rf_wr_en),
        .rf_rd_en    (rf_rd_en),
        .rf_addr     (rf_addr),
        .rf_wr_data  (rf_wr_data),
        .alu_en      (alu_en),
        .alu_fun     (alu_fun),
        .clk_gate_en (clk_gate_en),
        .cmd_err     (cmd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: the current frame is a byte queue; outputs follow from its opcode and length.
    logic              exp_wr = 1'b0, exp_rd = 1'b0, exp_alu = 1'b0, exp_err = 1'b0, exp_gate = 1'b0;
    logic [ADDR_W-1:0] exp_addr  = '0;
    logic [7:0]        exp_wdata = '0;
    logic [3:0]        exp_fun   = '0;
    logic [7:0]        frame[$];
    int                pend = 0;
    int                idle = 0;
    bit                fire_now = 1'b0, fire_prev = 1'b0;

    task automatic model_reset();
        frame.delete();
        pend = 0; idle = 0; fire_now = 1'b0; fire_prev = 1'b0;
        exp_wr = 1'b0; exp_rd = 1'b0; exp_alu = 1'b0; exp_err = 1'b0; exp_gate = 1'b0;
        exp_addr = '0; exp_wdata = '0; exp_fun = '0;
    endtask

    task automatic model_step();
        int         n;
        logic [7:0] op;
        fire_prev = fire_now;
        fire_now  = 1'b0;
        exp_wr = 1'b0; exp_rd = 1'b0; exp_alu = 1'b0; exp_err = 1'b0;
        if (pend != 0) begin
            if (rx_valid) exp_err = 1'b1;
            if (!tx_busy) begin
                if (pend == 2) begin exp_alu = 1'b1; fire_now = 1'b1; end
                else exp_rd = 1'b1;
                pend = 0;
                frame.delete();
            end
        end else if (rx_valid) begin
            frame.push_back(rx_data);
            idle = 0;
            n  = frame.size();
            op = frame[0];
            if (op == 8'hAA) begin
                if (n == 2) exp_addr = rx_data[ADDR_W-1:0];
                if (n == 3) begin exp_wdata = rx_data; exp_wr = 1'b1; frame.delete(); end
            end else if (op == 8'hBB) begin
                if (n == 2) begin exp_addr = rx_data[ADDR_W-1:0]; pend = 1; end
            end else if (op == 8'hCC) begin
                if (n == 2) begin exp_addr = '0; exp_wdata = rx_data; exp_wr = 1'b1; end
                if (n == 3) begin exp_addr = ADDR_W'(1); exp_wdata = rx_data; exp_wr = 1'b1; end
                if (n == 4) begin exp_fun = rx_data[3:0]; pend = 2; end
            end else if (op == 8'hDD) begin
                if (n == 2) begin exp_fun = rx_data[3:0]; pend = 2; end
            end else begin
                exp_err = 1'b1;
                frame.delete();
            end
        end else if (frame.size() != 0) begin
            idle++;
            if (idle >= TIMEOUT_CYC) begin exp_err = 1'b1; frame.delete(); end
        end
        op = (frame.size() != 0) ? frame[0] : 8'h00;
        exp_gate = fire_now || fire_prev || op == 8'hCC || op == 8'hDD;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_on && rst) begin
                check("cyc_wr_en",   32'(rf_wr_en),    32'(exp_wr));
                check("cyc_rd_en",   32'(rf_rd_en),    32'(exp_rd));
                check("cyc_alu_en",  32'(alu_en),      32'(exp_alu));
                check("cyc_cmd_err", 32'(cmd_err),     32'(exp_err));
                check("cyc_gate",    32'(clk_gate_en), 32'(exp_gate));
                check("cyc_addr",    32'(rf_addr),     32'(exp_addr));
                check("cyc_wdata",   32'(rf_wr_data),  32'(exp_wdata));
                check("cyc_fun",     32'(alu_fun),     32'(exp_fun));
            end
        end
    end

    task automatic pin(input string name, input logic [31:0] act, input logic [31:0] mdl,
                       input logic [31:0] lit);
        check({name, "_dut"}, act, lit);
        check({name, "_model"}, mdl, lit);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #2;
        rx_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, 32'(rf_wr_en),    0);
        check({tag, "_rd_en"}, 32'(rf_rd_en),    0);
        check({tag, "_addr"},  32'(rf_addr),     0);
        check({tag, "_wdata"}, 32'(rf_wr_data),  0);
        check({tag, "_alu"},   32'(alu_en),      0);
        check({tag, "_fun"},   32'(alu_fun),     0);
        check({tag, "_gate"},  32'(clk_gate_en), 0);
        check({tag, "_err"},   32'(cmd_err),     0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rd_early;

        repeat (3) @(posedge clk);
        #3;
        check_all_zero("reset");
        @(posedge clk);
        #2;
        rst    = 1'b1;
        cmp_on = 1'b1;
        tick(); tick();

        // Plain write: AA,05,3C
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C); #1;
        pin("wr_en",    32'(rf_wr_en),   32'(exp_wr),    1);
        pin("wr_addr",  32'(rf_addr),    32'(exp_addr),  5);
        pin("wr_data",  32'(rf_wr_data), 32'(exp_wdata), 'h3C);
        tick(); #1;
        pin("wr_single", 32'(rf_wr_en),  32'(exp_wr),    0);

        // Unknown opcode, then a normal write
        send_byte(8'h55); #1;
        pin("bad_op_err", 32'(cmd_err),  32'(exp_err), 1);
        pin("bad_op_wr",  32'(rf_wr_en), 32'(exp_wr),  0);
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'hFF); #1;
        pin("wr2_en",   32'(rf_wr_en),   32'(exp_wr),    1);
        pin("wr2_addr", 32'(rf_addr),    32'(exp_addr),  1);
        pin("wr2_data", 32'(rf_wr_data), 32'(exp_wdata), 'hFF);

        // Operand load plus ALU: CC,12,34,07
        tx_busy = 1'b0;
        send_byte(8'hCC); #1;
        pin("op_gate_on", 32'(clk_gate_en), 32'(exp_gate), 1);
        send_byte(8'h12); #1;
        pin("opa_addr", 32'(rf_addr),    32'(exp_addr),  0);
        pin("opa_data", 32'(rf_wr_data), 32'(exp_wdata), 'h12);
        send_byte(8'h34); #1;
        pin("opb_addr", 32'(rf_addr),    32'(exp_addr),  1);
        pin("opb_data", 32'(rf_wr_data), 32'(exp_wdata), 'h34);
        send_byte(8'h07); #1;
        pin("alu_wait", 32'(alu_en), 32'(exp_alu), 0);
        tick(); #1;
        pin("alu_en",    32'(alu_en),      32'(exp_alu),  1);
        pin("alu_fun",   32'(alu_fun),     32'(exp_fun),  7);
        pin("alu_gate0", 32'(clk_gate_en), 32'(exp_gate), 1);
        tick(); #1;
        pin("alu_gate1", 32'(clk_gate_en), 32'(exp_gate), 1);
        tick(); #1;
        pin("alu_gate2", 32'(clk_gate_en), 32'(exp_gate), 0);

        // Read held off by tx_busy for 20 cycles, with a dropped byte in between
        tx_busy  = 1'b1;
        rd_early = 0;
        send_byte(8'hBB); send_byte(8'h09); #1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                send_byte(8'h77); #1;
                pin("drop_err", 32'(cmd_err), 32'(exp_err), 1);
            end else begin
                tick(); #1;
            end
            if (rf_rd_en) rd_early++;
        end
        check("rd_held_busy", rd_early, 0);
        tx_busy = 1'b0;
        tick(); #1;
        pin("rd_en",   32'(rf_rd_en), 32'(exp_rd),   1);
        pin("rd_addr", 32'(rf_addr),  32'(exp_addr), 9);
        tick(); #1;
        pin("rd_single", 32'(rf_rd_en), 32'(exp_rd), 0);

        // Timeout after AA,03 and silence
        send_byte(8'hAA); send_byte(8'h03);
        repeat (15) tick();
        #1;
        pin("to_early", 32'(cmd_err), 32'(exp_err), 0);
        tick(); #1;
        pin("to_err",   32'(cmd_err),  32'(exp_err), 1);
        pin("to_no_wr", 32'(rf_wr_en), 32'(exp_wr),  0);
        tick(); #1;

        // Byte landing exactly on the timeout cycle wins
        send_byte(8'hAA); send_byte(8'h03);
        repeat (15) tick();
        send_byte(8'h5A); #1;
        pin("late_wr",   32'(rf_wr_en),   32'(exp_wr),    1);
        pin("late_addr", 32'(rf_addr),    32'(exp_addr),  3);
        pin("late_data", 32'(rf_wr_data), 32'(exp_wdata), 'h5A);
        pin("late_err",  32'(cmd_err),    32'(exp_err),   0);

        // Reset mid-frame after CC,12, then DD,02
        tick();
        send_byte(8'hCC); send_byte(8'h12); #1;
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (2) tick();
        rst = 1'b1;
        tick();
        send_byte(8'hDD); send_byte(8'h02); #1;
        tick(); #1;
        pin("rst_alu_en",  32'(alu_en),  32'(exp_alu), 1);
        pin("rst_alu_fun", 32'(alu_fun), 32'(exp_fun), 2);
        repeat (3) tick();

        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
